// File: rtl/psl_pkg.sv
// Shared types and default widths for the parameter stream loader.
package psl_pkg;

    localparam int PSL_NUM_CH = 16;
    localparam int PSL_DATA_W = 32;
    localparam int PSL_ADDR_W = 16;
    localparam int PSL_LEN_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } psl_state_e;

    // Descriptor field widths follow the package defaults above.
    typedef struct packed {
        logic [PSL_ADDR_W-1:0] base;
        logic [PSL_LEN_W-1:0]  len;
    } psl_desc_t;

endpackage

// File: rtl/psl_fifo2.sv
// Two-entry synchronous FIFO; simultaneous push and pop is legal even when full.
module psl_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] store [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst_) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    // NOTE: storage has no reset; occupancy gates every use of the head word.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/param_stream_loader.sv
// Walks a descriptor table and streams each channel's words from a shared memory.
// Optional per-channel checksum outputs are enabled by defining PSL_CHECKSUM_EN.
module param_stream_loader
    import psl_pkg::*;
#(
    parameter int NUM_CH = PSL_NUM_CH,
    parameter int DATA_W = PSL_DATA_W,
    parameter int ADDR_W = PSL_ADDR_W,
    parameter int LEN_W  = PSL_LEN_W,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef PSL_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] ch_sum,
    output logic              ch_sum_valid
`endif
);

    psl_state_e        state;
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              rd_pend;
    logic              rd_pend_last;
    logic              done_r;
    psl_desc_t         desc [NUM_CH];
    psl_desc_t         cur_desc;
    logic              more_after;

    logic [DATA_W:0]   fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              head_last;
    logic [2:0]        occ;
    logic              issue;

    assign cur_desc  = desc[ch];
    assign head_last = fifo_head[DATA_W];
    assign pop       = !fifo_empty && out_ready[ch];

    // Reads in flight count against buffer space, so the FIFO can never overflow.
    assign occ   = 3'(fifo_count) + 3'(rd_pend) - 3'(pop);
    assign issue = (state == ST_STREAM) && (remaining != '0) && (occ < 3'd2)
                   && !(fifo_full && !pop);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        more_after = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i > int'(ch) && desc[i].len != '0) more_after = 1'b1;
        end
    end

    psl_fifo2 #(.W(DATA_W + 1)) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (rd_pend),
        .pop   (pop),
        .din   ({rd_pend_last, mem_rdata}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: sequential state uses non-blocking assignments only; later ones in the block win.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state        <= ST_IDLE;
            ch           <= '0;
            addr         <= '0;
            remaining    <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            done_r       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) desc[i] <= '0;
        end else begin
            done_r       <= 1'b0;
            rd_pend      <= issue;
            rd_pend_last <= issue && (remaining == LEN_W'(1));
            if (issue) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (cfg_we && int'(cfg_ch) < NUM_CH) begin
                        desc[cfg_ch] <= '{base: cfg_base, len: cfg_len};
                    end
                    if (start) begin
                        state <= ST_SCAN;
                        ch    <= '0;
                    end
                end
                ST_SCAN: begin
                    if (cur_desc.len == '0) begin
                        if (ch == CH_W'(NUM_CH - 1)) begin
                            state  <= ST_IDLE;
                            done_r <= 1'b1;
                        end else begin
                            ch <= ch + CH_W'(1);
                        end
                    end else begin
                        addr      <= cur_desc.base;
                        remaining <= cur_desc.len;
                        state     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (issue && remaining == LEN_W'(1)) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Trailing empty channels are skipped here so done follows the final pop directly.
                    if (pop && head_last) begin
                        if (more_after) begin
                            state <= ST_SCAN;
                            ch    <= ch + CH_W'(1);
                        end else begin
                            state  <= ST_IDLE;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = '0;
        if (!fifo_empty) out_valid[ch] = 1'b1;
    end

    assign out_data = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign out_last = !fifo_empty && head_last;
    assign mem_en   = issue;
    assign mem_addr = addr;
    assign busy     = (state != ST_IDLE);
    assign done     = done_r;

`ifdef PSL_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst_) begin
            ch_sum       <= '0;
            ch_sum_valid <= 1'b0;
        end else begin
            ch_sum_valid <= pop && head_last;
            if (state == ST_SCAN && cur_desc.len != '0) begin
                ch_sum <= '0;
            end else if (pop) begin
                ch_sum <= ch_sum + out_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_stream_loader.sv
// Directed bench for param_stream_loader with a behavioural parameter memory.
module tb_param_stream_loader;

    localparam int NUM_CH = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 16;
    localparam int CH_W   = 4;

    logic              clk = 1'b0;
    logic              rst_ = 1'b1;
    logic              start = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] out_data;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready = '1;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef PSL_CHECKSUM_EN
    logic [DATA_W-1:0] ch_sum;
    logic              ch_sum_valid;
    int                sumv_cnt = 0;
    logic [DATA_W-1:0] last_sum = '0;
`endif

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic [15:0] addr_q [$];

    param_stream_loader dut (
        .clk       (clk),
        .rst_      (rst_),
        .start     (start),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef PSL_CHECKSUM_EN
        ,
        .ch_sum       (ch_sum),
        .ch_sum_valid (ch_sum_valid)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [15:0] a);
        case (a)
            16'h2000: return 32'h0000_0001;
            16'h2001: return 32'h0000_0002;
            16'h2002: return 32'h0000_0003;
            16'h2003: return 32'hFFFF_FFFF;
            default:  return {~a, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            mem_rdata <= mem_fn(mem_addr);
            addr_q.push_back(mem_addr);
        end
        if (done === 1'b1) done_cnt++;
`ifdef PSL_CHECKSUM_EN
        if (ch_sum_valid === 1'b1) begin
            sumv_cnt++;
            last_sum = ch_sum;
        end
`endif
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int ch, input logic [15:0] base, input int len);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_base = base;
        cfg_len  = LEN_W'(len);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic start_pass();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumes words of one channel until `stop` have been accepted, checking each against the memory model.
    task automatic expect_channel(input int ch, input logic [15:0] base, input int len,
                                  input int stop, input bit rnd, output int span);
        int idx = 0;
        int cyc = 0;
        int first = -1;
        logic [NUM_CH-1:0] ev;
        logic [15:0] a;
        ev = '0;
        ev[ch] = 1'b1;
        while (idx < stop && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            out_ready = '1;
            if (rnd) out_ready[ch] = 1'($urandom_range(0, 1));
            if (out_valid !== '0) begin
                if (first < 0) first = cyc;
                a = base + 16'(idx);
                check($sformatf("valid_ch%0d_w%0d", ch, idx), out_valid, ev);
                check($sformatf("data_ch%0d_w%0d", ch, idx), out_data, mem_fn(a));
                check($sformatf("last_ch%0d_w%0d", ch, idx), out_last, (idx == len - 1));
                if (out_ready[ch]) idx++;
            end
        end
        check($sformatf("words_ch%0d", ch), idx, stop);
        span = cyc - first + 1;
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_low"}, busy, 1'b0);
        @(negedge clk);
        check({tag, "_done_single"}, done, 1'b0);
    endtask

    initial begin
        int span;
        int dc;
        logic [15:0] wrap_exp [4];
        wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", out_valid, '0);
        check("rst_last", out_last, 1'b0);
        check("rst_data", out_data, '0);
        rst_ = 1'b0;

        // Single long channel, ready high; a write while busy must be ignored
        out_ready = '0;
        cfg(0, 16'h0000, 2304);
        dc = done_cnt;
        start_pass();
        check("busy_after_start", busy, 1'b1);
        cfg(3, 16'h0040, 5);
        expect_channel(0, 16'h0000, 2304, 2304, 1'b0, span);
        check("ch0_no_gap_span", span, 2304);
        check_done("pass1");
        check("pass1_done_count", done_cnt - dc, 1);

        // Two channels, ch0 skipped; ch2 written in the same cycle as start
        cfg(0, 16'h0000, 0);
        cfg(1, 16'd100, 180);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 4'd2; cfg_base = 16'd500; cfg_len = 16'd20;
        start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        expect_channel(1, 16'd100, 180, 180, 1'b0, span);
        expect_channel(2, 16'd500, 20, 20, 1'b0, span);
        check_done("pass2");

        // Same descriptors with a randomly stalling consumer
        dc = done_cnt;
        start_pass();
        expect_channel(1, 16'd100, 180, 180, 1'b1, span);
        expect_channel(2, 16'd500, 20, 20, 1'b1, span);
        check_done("pass3");
        check("pass3_done_count", done_cnt - dc, 1);

        // Reset in the middle of a stream aborts silently and clears descriptors
        cfg(1, 16'h0000, 0);
        cfg(2, 16'h0000, 0);
        cfg(0, 16'h0000, 100);
        start_pass();
        expect_channel(0, 16'h0000, 100, 37, 1'b0, span);
        dc = done_cnt;
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_valid", out_valid, '0);
        check("midrst_mem_en", mem_en, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rst_ = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_done", done_cnt - dc, 0);

        // Empty pass after reset: done NUM_CH+1 cycles after start
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= NUM_CH + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k <= NUM_CH) begin
                check($sformatf("empty_busy_c%0d", k), busy, 1'b1);
                check($sformatf("empty_done_c%0d", k), done, 1'b0);
            end else begin
                check("empty_done", done, 1'b1);
                check("empty_busy_low", busy, 1'b0);
                check("empty_no_valid", out_valid, '0);
            end
        end

        // Reprogrammed pass restarts from word 0
        cfg(0, 16'h0000, 50);
        start_pass();
        expect_channel(0, 16'h0000, 50, 50, 1'b0, span);
        check_done("restart");

        // Address wrap at the top of memory
        cfg(0, 16'h0000, 0);
        cfg(5, 16'hFFFE, 4);
        addr_q.delete();
        start_pass();
        expect_channel(5, 16'hFFFE, 4, 4, 1'b0, span);
        check_done("wrap");
        check("wrap_read_count", addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_addr%0d", i), (i < addr_q.size()) ? addr_q[i] : 16'hxxxx, wrap_exp[i]);
        end

`ifdef PSL_CHECKSUM_EN
        // Checksum wraps modulo 2^32: 1+2+3+0xFFFFFFFF = 5
        cfg(5, 16'h0000, 0);
        cfg(7, 16'h2000, 4);
        dc = sumv_cnt;
        start_pass();
        expect_channel(7, 16'h2000, 4, 4, 1'b0, span);
        check_done("csum");
        check("csum_pulse_count", sumv_cnt - dc, 1);
        check("csum_value", last_sum, 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_stream_loader.md
Name: param_stream_loader

Overview:
- Synthesizable replacement for per-stream parameter feeding (image, per-layer kernels, biases).
- Reads words from one shared single-port parameter memory.
- Walks a programmable descriptor table of NUM_CH channels, each with a base address and a length, in channel order.
- Delivers each channel's words to its consumer layer over a valid/ready handshake, with a 2-entry output buffer so a stalled consumer never loses data.

Parameters:
- NUM_CH, 16: number of streams/descriptors (image + conv/dense weights + biases).
- DATA_W, 32: word width.
- ADDR_W, 16: parameter memory address width.
- LEN_W, 16: descriptor length width (words).
- CH_W, $clog2(NUM_CH): channel index width (derived).

Ports:
- clk  in  1  clock
- rst_  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begin a pass over all descriptors
- cfg_we  in  1  descriptor write strobe
- cfg_ch  in  CH_W  descriptor index
- cfg_base  in  ADDR_W  descriptor base address
- cfg_len  in  LEN_W  descriptor length; 0 = channel skipped
- mem_en  out  1  memory read enable
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_en
- out_data  out  DATA_W  stream word (shared by all channels)
- out_valid  out  NUM_CH  one-hot; bit c set = word for channel c
- out_ready  in  NUM_CH  consumer ready, per channel
- out_last  out  1  final word of the current channel
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse after the last word of the pass is accepted

Behaviour:
- Reset: all outputs 0; FSM to IDLE; buffer emptied; outstanding read discarded; all descriptors cleared to base 0, len 0. Reset mid-pass aborts silently with no done pulse.
- Descriptor writes:
  - Accepted only in IDLE; ignored while busy.
  - A write and a start in the same cycle: the write lands first and the pass uses the new value.
- FSM states: IDLE -> SCAN -> STREAM -> DRAIN -> IDLE.
- IDLE:
  - start=1 -> SCAN, with channel=0 and busy=1 from the next cycle.
  - start while busy is ignored.
- SCAN: per cycle, if len[ch]==0 advance ch; else load addr=base, remaining=len and go to STREAM. If ch passes NUM_CH-1, go to IDLE with a done pulse (empty pass: done 2 cycles after start when all lengths are 0 and NUM_CH is 1; NUM_CH+1 cycles in general).
- STREAM:
  - Issue mem_en when (buffer occupancy + outstanding reads) < 2 and remaining > 0; addr increments by 1 per issued read.
  - Address wraps modulo 2^ADDR_W.
  - Returned data is pushed into the 2-entry FIFO.
  - After the last read is issued -> DRAIN.
- DRAIN: wait until the FIFO is empty, then the next channel goes to SCAN with ch+1.
- Output:
  - FIFO head drives out_data, with out_valid[ch] set while the FIFO is non-empty.
  - Pop when out_valid[ch] && out_ready[ch].
  - out_data/out_valid hold stable until accepted.
  - out_last = 1 on the head word that is the channel's final word.
- Throughput: 1 word/cycle with ready held high. First word is visible 2 cycles after the first mem_en.
- Channel switch: no word of channel c+1 may be presented before channel c's last word is accepted.
- Simultaneous push and pop with occupancy 2 is legal; occupancy never exceeds 2.
- done asserts the cycle after the final pop of the last nonzero channel. busy drops in that same cycle.

Optional Feature:
- PSL_CHECKSUM_EN:
  - When defined, adds output ch_sum [DATA_W] and ch_sum_valid [1].
  - ch_sum is the modulo-2^DATA_W sum of all words accepted on the current channel, cleared on entering STREAM.
  - ch_sum_valid pulses 1 cycle with the final sum after out_last is accepted.
  - Both are 0 at reset.
- When not defined: the ports are absent and there is no adder logic.

Decomposition:
- Package psl_pkg holds:
  - FSM state enum (IDLE, SCAN, STREAM, DRAIN).
  - Descriptor struct {base, len}.
  - Default widths.
- One sub-module: psl_fifo2, the 2-entry synchronous FIFO with push, pop, full, empty and count, reset by rst_.

Test Plan:
- Desc0 {base=0,len=2304}, others len 0, ready=1 -> 2304 words on out_valid[0] matching memory[0..2303]; out_last on word 2303; done once; no gap after the first word.
- Desc1 {base=100,len=180}, desc2 {base=500,len=20} -> ch1 stream fully precedes ch2; ch0 skipped; done after word 519 is accepted.
- Same as above with out_ready[1] toggling randomly (50%) -> no loss or duplication; occupancy ≤2; out_data stable during stalls.
- Desc {base=0xFFFE,len=4} -> addresses FFFE, FFFF, 0000, 0001.
- rst_ asserted mid-STREAM at word 37, then a new start -> no done on the aborted pass; new pass restarts from word 0 with descriptors cleared (reprogram first).
- PSL_CHECKSUM_EN with words 1,2,3,0xFFFFFFFF -> ch_sum=5, ch_sum_valid pulses once.
